// File: rtl/reg_file.sv
// RV32I integer register file: two combinational read ports with same-cycle
// write-back bypass, one write port, and a pending-write scoreboard for RAW stalls.
module reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             rd_we,
    input  logic [AW-1:0]    rd_addr,
    input  logic [XLEN-1:0]  rd_data,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic             use_rs1,
    input  logic             use_rs2,
    output logic             stall,
    output logic [NREGS-1:0] busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             byp1;
    logic             byp2;
    logic             stall_c;

    // A pending source is not a hazard when its producer is writing back right now.
    assign byp1    = rd_we && (rd_addr == rs1_addr);
    assign byp2    = rd_we && (rd_addr == rs2_addr);
    assign stall_c = (use_rs1 && busy[rs1_addr] && !byp1) ||
                     (use_rs2 && busy[rs2_addr] && !byp2);

    assign stall    = stall_c;
    assign busy_vec = busy;

    always_comb begin
        rs1_data = '0;
        if (rst_n && (rs1_addr != '0)) begin
            if (byp1) begin
                rs1_data = rd_data;
            end else begin
                rs1_data = regs[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rst_n && (rs2_addr != '0)) begin
            if (byp2) begin
                rs2_data = rd_data;
            end else begin
                rs2_data = regs[rs2_addr];
            end
        end
    end

    // Set is applied after clear so a new producer issued in the same cycle wins.
    always_comb begin
        busy_next = busy;
        for (int r = 1; r < NREGS; r++) begin
            if (rd_we && (rd_addr == AW'(r))) begin
                busy_next[r] = 1'b0;
            end
            if (issue_valid && !stall_c && (issue_rd == AW'(r))) begin
                busy_next[r] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            busy <= busy_next;
            if (rd_we && (rd_addr != '0)) begin
                regs[rd_addr] <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, reads, x0 handling, bypass,
// RAW stall and scoreboard corner cases, and asynchronous mid-cycle reset.
module tb_reg_file;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    rs1_addr;
    logic [AW-1:0]    rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             rd_we;
    logic [AW-1:0]    rd_addr;
    logic [XLEN-1:0]  rd_data;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic             use_rs1;
    logic             use_rs2;
    logic             stall;
    logic [NREGS-1:0] busy_vec;

    int passed = 0;
    int total  = 0;

    reg_file #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rd_we      (rd_we),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .use_rs1    (use_rs1),
        .use_rs2    (use_rs2),
        .stall      (stall),
        .busy_vec   (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one rising edge, then step off the edge before driving/sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        rd_we   = 1'b1;
        rd_addr = a;
        rd_data = d;
        tick();
        rd_we   = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        rd_we       = 1'b0;
        rd_addr     = '0;
        rd_data     = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;

        // Reads return 0 while reset is held, even with a matching write-back
        #2;
        rd_we = 1'b1; rd_addr = 5'd3; rd_data = 32'h1234_5678; rs1_addr = 5'd3;
        #1;
        chk("rd_during_reset", rs1_data, 32'h0);
        rd_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Test 1: all registers read 0, no busy, no stall
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            rs1_addr = AW'(i);
            rs2_addr = AW'(NREGS - 1 - i);
            #1;
            chk($sformatf("reset_rs1_x%0d", i), rs1_data, 32'h0);
            chk($sformatf("reset_rs2_x%0d", NREGS - 1 - i), rs2_data, 32'h0);
        end
        chk("reset_busy", busy_vec, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        use_rs1 = 1'b0; use_rs2 = 1'b0;

        // Test 2: write x5=20, x6=30, read back and add
        wr(5'd5, 32'd20);
        wr(5'd6, 32'd30);
        rs1_addr = 5'd5; rs2_addr = 5'd6;
        #1;
        chk("read_x5", rs1_data, 32'd20);
        chk("read_x6", rs2_data, 32'd30);
        chk("alu_add", rs1_data + rs2_data, 32'd50);

        // Test 3: x0 writes dropped, no bypass onto x0, issue_rd=0 never busy
        rs1_addr = 5'd0;
        rd_we = 1'b1; rd_addr = 5'd0; rd_data = 32'hDEAD_BEEF;
        #1;
        chk("x0_no_bypass", rs1_data, 32'h0);
        tick();
        rd_we = 1'b0;
        #1;
        chk("x0_after_write", rs1_data, 32'h0);
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("x0_issue_busy", busy_vec, 32'h0);

        // Test 4: same-cycle bypass then stored value
        rs1_addr = 5'd7;
        rd_we = 1'b1; rd_addr = 5'd7; rd_data = 32'd8;
        #1;
        chk("bypass_x7", rs1_data, 32'd8);
        tick();
        rd_we = 1'b0;
        #1;
        chk("stored_x7", rs1_data, 32'd8);

        // Test 5: RAW stall on x9, stalled issue does not set busy, write-back clears
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("busy_x9", busy_vec, 32'h0000_0200);
        rs1_addr = 5'd9; use_rs1 = 1'b0;
        #1;
        chk("no_use_no_stall", {31'b0, stall}, 32'h0);
        use_rs1 = 1'b1;
        #1;
        chk("stall_rs1_x9", {31'b0, stall}, 32'h1);
        use_rs1 = 1'b0; rs2_addr = 5'd9; use_rs2 = 1'b1;
        #1;
        chk("stall_rs2_x9", {31'b0, stall}, 32'h1);
        issue_valid = 1'b1; issue_rd = 5'd10;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("stalled_issue_ignored", busy_vec, 32'h0000_0200);
        use_rs2 = 1'b0; use_rs1 = 1'b1;
        rd_we = 1'b1; rd_addr = 5'd9; rd_data = 32'd3;
        #1;
        chk("wb_unstall", {31'b0, stall}, 32'h0);
        chk("wb_bypass_x9", rs1_data, 32'd3);
        tick();
        rd_we = 1'b0;
        #1;
        chk("busy_x9_cleared", busy_vec, 32'h0);
        chk("stored_x9", rs1_data, 32'd3);
        chk("stall_after_wb", {31'b0, stall}, 32'h0);
        use_rs1 = 1'b0;

        // Test 6: set and clear of x4 in the same cycle keeps it busy
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        #1;
        chk("busy_x4", busy_vec, 32'h0000_0010);
        rd_we = 1'b1; rd_addr = 5'd4; rd_data = 32'd44;
        tick();
        rd_we = 1'b0; issue_valid = 1'b0;
        rs1_addr = 5'd4;
        #1;
        chk("set_wins_x4", busy_vec, 32'h0000_0010);
        chk("stored_x4", rs1_data, 32'd44);

        // Clearing an idle register is harmless
        wr(5'd12, 32'd12);
        #1;
        chk("idle_clear_x12", busy_vec, 32'h0000_0010);

        // Asynchronous reset mid-cycle, no clock edge needed
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy_vec, 32'h0);
        chk("async_rst_read", rs1_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_x4", rs1_data, 32'h0);
        rs1_addr = 5'd5; rs2_addr = 5'd7;
        #1;
        chk("post_rst_x5", rs1_data, 32'h0);
        chk("post_rst_x7", rs2_data, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
